bcd_scan_counter: RTL and testbench

- 4-digit BCD up/down counter with load, plus a time-multiplexed digit scanner.
- Drives the existing 7-segment decoder: data[3:0] connects directly to the decoder's data input, and digit_sel drives the display digit enables.
- Leading-zero blanking emits code 4'hF, which the decoder's default branch renders as all segments off.

---
 rtl/bcd_scan_counter.sv | 137 +++++++++++++
 tb/tb_bcd_scan_counter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_counter.sv
// rtl/bcd_scan_counter.sv - 4-digit BCD up/down counter with 7-segment digit scanner
//
// Purpose: counts in BCD (0000..9999) up or down with synchronous load and
// a one-cycle wrap pulse, and time-multiplexes the four digits onto a single
// 4-bit code bus for the existing 7-segment decoder.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   en         count enable, one step per cycle
//   up         1 = increment, 0 = decrement
//   load       synchronous load of load_val (nibbles > 9 become 0)
//   load_val   four BCD digits, [3:0] is digit 0
//   count      registered BCD count
//   wrap       one-cycle pulse when count shows a wrapped value
//   data       BCD code of the scanned digit, 4'hF when blanked
//   digit_sel  one-hot enable of the scanned digit

module bcd_scan_counter #(
  parameter int SCAN_DIV = 1000,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        up,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] count,
  output logic        wrap,
  output logic [3:0]  data,
  output logic [3:0]  digit_sel
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

  logic [15:0] div;
  logic [1:0]  idx;

  logic [15:0] count_step;
  logic        step_carry;
  logic [15:0] load_clamped;
  logic [3:0]  digit;
  logic        blank;

  // Ripple one step through the digits. The carry/borrow that survives past
  // digit 3 means every digit rolled over, which is exactly the wrap case.
  always_comb begin
    logic [3:0] d;
    count_step = count;
    step_carry = 1'b1;
    d          = 4'h0;
    for (int i = 0; i < 4; i++) begin
      d = count[4*i +: 4];
      if (step_carry) begin
        if (up) begin
          if (d >= 4'd9) begin
            d = 4'd0;
          end else begin
            d          = d + 4'd1;
            step_carry = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            d = 4'd9;
          end else begin
            d          = d - 4'd1;
            step_carry = 1'b0;
          end
        end
      end
      count_step[4*i +: 4] = d;
    end
  end

  // Non-BCD nibbles on load are forced to zero so count is always valid BCD.
  always_comb begin
    load_clamped = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      load_clamped[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= 16'h0000;
      wrap      <= 1'b0;
      div       <= 16'h0000;
      idx       <= 2'd0;
      digit_sel <= 4'b0001;
    end else begin
      if (load) begin
        count <= load_clamped;
        wrap  <= 1'b0;
      end else if (en) begin
        count <= count_step;
        wrap  <= step_carry;
      end else begin
        wrap  <= 1'b0;
      end

      // Scanner runs regardless of en/load.
      if (div == DIV_LAST) begin
        div       <= 16'h0000;
        idx       <= idx + 2'd1;
        // Rotating the one-hot keeps digit_sel == one-hot(idx) since both
        // start aligned at reset and always advance together.
        digit_sel <= {digit_sel[2:0], digit_sel[3]};
      end else begin
        div       <= div + 16'h0001;
      end
    end
  end

  // A digit is a leading zero when it and every higher digit are zero.
  always_comb begin
    digit = 4'h0;
    blank = 1'b0;
    case (idx)
      2'd0: digit = count[3:0];
      2'd1: begin
        digit = count[7:4];
        blank = (count[15:4] == 12'h000);
      end
      2'd2: begin
        digit = count[11:8];
        blank = (count[15:8] == 8'h00);
      end
      default: begin
        digit = count[15:12];
        blank = (count[15:12] == 4'h0);
      end
    endcase
    data = (LZ_BLANK && blank) ? 4'hF : digit;
  end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb/tb_bcd_scan_counter.sv - self-checking bench for bcd_scan_counter
module tb_bcd_scan_counter;

  logic        clk = 1'b0;
  logic        reset, en, up, load;
  logic [15:0] load_val;

  logic [15:0] count_a, count_b, count_c;
  logic        wrap_a, wrap_b, wrap_c;
  logic [3:0]  data_a, data_b, data_c;
  logic [3:0]  sel_a, sel_b, sel_c;

  always #5 clk = ~clk;

  bcd_scan_counter #(.SCAN_DIV(2), .LZ_BLANK(1'b1)) u_a (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count_a), .wrap(wrap_a), .data(data_a), .digit_sel(sel_a));

  bcd_scan_counter #(.SCAN_DIV(2), .LZ_BLANK(1'b0)) u_b (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count_b), .wrap(wrap_b), .data(data_b), .digit_sel(sel_b));

  bcd_scan_counter #(.SCAN_DIV(3), .LZ_BLANK(1'b1)) u_c (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count_c), .wrap(wrap_c), .data(data_c), .digit_sel(sel_c));

  int checks   = 0;
  int failures = 0;

  // Reference model: count as a plain decimal integer, scan position derived
  // from the number of cycles since reset.
  int mv    = 0;
  bit mwrap = 1'b0;
  int t     = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0d)", name, act, exp, t);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int clamp_val(input logic [15:0] lv);
    int r = 0;
    int p = 1;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] n;
      n = lv[4*i +: 4];
      if (n <= 4'd9) r += int'(n) * p;
      p *= 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] exp_data(input int v, input int ix, input bit lz);
    int p = 1;
    for (int k = 0; k < ix; k++) p *= 10;
    if (lz && ix > 0 && v < p) return 4'hF;
    return 4'((v / p) % 10);
  endfunction

  function automatic logic [3:0] onehot(input int ix);
    logic [3:0] one;
    one = 4'b0001;
    return one << ix;
  endfunction

  task automatic check_all();
    int ia;
    int ic;
    ia = (t / 2) % 4;
    ic = (t / 3) % 4;
    chk("count_a", count_a, to_bcd(mv));
    chk("count_b", count_b, to_bcd(mv));
    chk("count_c", count_c, to_bcd(mv));
    chk("wrap_a", 16'(wrap_a), 16'(mwrap));
    chk("wrap_c", 16'(wrap_c), 16'(mwrap));
    chk("sel_a", 16'(sel_a), 16'(onehot(ia)));
    chk("sel_b", 16'(sel_b), 16'(onehot(ia)));
    chk("sel_c", 16'(sel_c), 16'(onehot(ic)));
    chk("data_a", 16'(data_a), 16'(exp_data(mv, ia, 1'b1)));
    chk("data_b", 16'(data_b), 16'(exp_data(mv, ia, 1'b0)));
    chk("data_c", 16'(data_c), 16'(exp_data(mv, ic, 1'b1)));
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) begin
      mv = 0; mwrap = 1'b0; t = 0;
    end else begin
      t++;
      if (load) begin
        mv = clamp_val(load_val); mwrap = 1'b0;
      end else if (en) begin
        if (up) begin
          mwrap = (mv == 9999); mv = (mv + 1) % 10000;
        end else begin
          mwrap = (mv == 0); mv = (mv + 9999) % 10000;
        end
      end else begin
        mwrap = 1'b0;
      end
    end
    #1;
    check_all();
  endtask

  typedef struct {
    logic        reset, en, up, load;
    logic [15:0] load_val;
    logic [15:0] exp_count;
    logic        exp_wrap;
  } vec_t;

  vec_t vt[14];
  logic [3:0] exp_sel[8];
  logic [3:0] exp_da[8];
  logic [3:0] exp_db[8];

  initial begin
    reset = 1'b1; en = 1'b1; up = 1'b1; load = 1'b1; load_val = 16'h1234;

    vt[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 16'h0000, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 16'h0000, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0998, 16'h0998, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0999, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h1000, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h1001, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h9999, 16'h9999, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h9999, 1'b1};
    vt[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h9998, 1'b0};
    vt[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h9998, 1'b0};
    vt[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h3A5F, 16'h3050, 1'b0};
    vt[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h3050, 1'b0};

    exp_sel = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000};
    exp_da  = '{4'h2, 4'h2, 4'h4, 4'h4, 4'hF, 4'hF, 4'hF, 4'hF};
    exp_db  = '{4'h2, 4'h2, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0};

    // Directed vectors
    for (int i = 0; i < 14; i++) begin
      reset = vt[i].reset; en = vt[i].en; up = vt[i].up;
      load = vt[i].load; load_val = vt[i].load_val;
      step();
      chk("vec_count", count_a, vt[i].exp_count);
      chk("vec_wrap", 16'(wrap_a), 16'(vt[i].exp_wrap));
      if (i == 1) begin
        chk("rst_sel", 16'(sel_a), 16'h0001);
        chk("rst_data", 16'(data_a), 16'h0000);
      end
    end

    // Scan pattern with count 0042, aligned to scan index 0 of u_a/u_b
    reset = 1'b0; en = 1'b0; load = 1'b1; load_val = 16'h0042;
    step();
    load = 1'b0;
    for (int k = 0; k < 16 && (t % 8) != 0; k++) step();
    chk("scan_align", 16'(t % 8), 16'h0000);
    for (int j = 0; j < 8; j++) begin
      chk("scan_sel", 16'(sel_a), 16'(exp_sel[j]));
      chk("scan_data_lz", 16'(data_a), 16'(exp_da[j]));
      chk("scan_data_nolz", 16'(data_b), 16'(exp_db[j]));
      step();
    end

    // Reset mid-scan on u_c at index 2, divider 1
    en = 1'b1; up = 1'b1;
    for (int k = 0; k < 24 && (t % 12) != 7; k++) step();
    chk("mid_sel_pre", 16'(sel_c), 16'b0100);
    reset = 1'b1;
    step();
    chk("mid_count", count_c, 16'h0000);
    chk("mid_sel", 16'(sel_c), 16'b0001);
    reset = 1'b0;
    step();
    chk("mid_sel_t1", 16'(sel_c), 16'b0001);
    step();
    chk("mid_sel_t2", 16'(sel_c), 16'b0001);
    step();
    chk("mid_sel_t3", 16'(sel_c), 16'b0010);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      load  = ($urandom_range(0, 7) == 0);
      en    = ($urandom_range(0, 3) != 0);
      up    = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: load_val = 16'h9999;
        1: load_val = 16'h0000;
        2: load_val = 16'h9998;
        3: load_val = 16'h0001;
        default: load_val = 16'($urandom);
      endcase
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
